// File: rtl/price_pkg.sv
// Shared types for the price band scheduler: band state encoding and default price width.
package price_pkg;

  localparam int PRICE_W_DEF = 8;

  typedef enum logic [1:0] {
    BAND = 2'b01,
    HIGH = 2'b11,
    LOW  = 2'b10
  } band_state_e;

endpackage

// File: rtl/price_band_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request at or after the pointer.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_reg;
  logic [PW-1:0] ptr_next;
  logic          found;
  int            idx;

  // Grants are only ever issued to requesters, so a grant is always an accept.
  always_comb begin
    grant    = '0;
    ptr_next = ptr_reg;
    found    = 1'b0;
    idx      = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr_reg) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        ptr_next   = (idx == N - 1) ? '0 : PW'(idx + 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) ptr_reg <= '0;
    else       ptr_reg <= ptr_next;
  end

endmodule

// File: rtl/price_band_scheduler.sv
// Shared band-evaluation engine for NUM_CH price feeds with per-channel thresholds,
// debounce counters and band state; state changes are reported as one-cycle events.
module price_band_scheduler
  import price_pkg::*;
#(
  parameter int NUM_CH           = 4,
  parameter int PRICE_W          = PRICE_W_DEF,
  parameter int DEF_UPPER        = 105,
  parameter int DEF_LOWER        = 95,
  parameter int DEBOUNCE_SAMPLES = 3,
  localparam int CHW             = $clog2(NUM_CH)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_CH-1:0]         req_valid,
  input  logic [NUM_CH*PRICE_W-1:0] req_price,
  output logic [NUM_CH-1:0]         req_ready,
  input  logic                      cfg_we,
  input  logic [CHW-1:0]            cfg_ch,
  input  logic [PRICE_W-1:0]        cfg_upper,
  input  logic [PRICE_W-1:0]        cfg_lower,
  output logic                      cfg_err,
  output logic [NUM_CH*2-1:0]       state_out,
  output logic                      evt_valid,
  output logic [CHW-1:0]            evt_ch,
  output logic [1:0]                evt_state
);

  band_state_e        state_reg [NUM_CH];
  logic [PRICE_W-1:0] upper_reg [NUM_CH];
  logic [PRICE_W-1:0] lower_reg [NUM_CH];
  logic [3:0]         cnt_reg   [NUM_CH];
  logic               dir_reg   [NUM_CH];  // 1 = run of above samples, 0 = below

  logic [NUM_CH-1:0]  eligible;
  logic [NUM_CH-1:0]  grant;
  logic               cfg_ok;
  logic               cfg_hit;

  assign cfg_ok  = cfg_lower < cfg_upper;
  assign cfg_hit = cfg_we && cfg_ok && ({1'b0, cfg_ch} < (CHW + 1)'(NUM_CH));

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign eligible[gi]         = req_valid[gi] && !(cfg_we && cfg_ch == CHW'(gi));
      assign state_out[gi*2 +: 2] = state_reg[gi];
    end
  endgenerate

  rr_arbiter #(.N(NUM_CH)) u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (eligible),
    .grant (grant)
  );

  assign req_ready = grant;

  logic               acc_valid;
  logic [CHW-1:0]     acc_ch;
  logic [PRICE_W-1:0] acc_price;

  always_comb begin
    acc_valid = |grant;
    acc_ch    = '0;
    acc_price = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant[i]) begin
        acc_ch    = CHW'(i);
        acc_price = req_price[i*PRICE_W +: PRICE_W];
      end
    end
  end

  band_state_e cur_state;
  logic [3:0]  cur_cnt;
  logic        cur_dir;
  logic        above;
  logic        below;
  band_state_e nxt_state;
  logic [3:0]  nxt_cnt;
  logic        nxt_dir;
  logic [4:0]  run_cnt;

  always_comb begin
    cur_state = state_reg[acc_ch];
    cur_cnt   = cnt_reg[acc_ch];
    cur_dir   = dir_reg[acc_ch];
    above     = acc_price > upper_reg[acc_ch];
    below     = acc_price < lower_reg[acc_ch];
    nxt_state = cur_state;
    nxt_cnt   = cur_cnt;
    nxt_dir   = cur_dir;
    run_cnt   = 5'd0;
    case (cur_state)
      BAND: begin
        if (above || below) begin
          // cnt==0 means no run in progress, so the stored direction is meaningless.
          run_cnt = (cur_cnt != 4'd0 && cur_dir == above) ? {1'b0, cur_cnt} + 5'd1 : 5'd1;
          nxt_dir = above;
          if (run_cnt >= 5'(DEBOUNCE_SAMPLES)) begin
            nxt_state = above ? HIGH : LOW;
            nxt_cnt   = 4'd0;
          end else begin
            nxt_cnt = run_cnt[3:0];
          end
        end else begin
          nxt_cnt = 4'd0;
        end
      end
      HIGH: begin
        if (!above) begin
          nxt_state = BAND;
          nxt_cnt   = below ? 4'd1 : 4'd0;
          nxt_dir   = 1'b0;
        end
      end
      LOW: begin
        if (!below) begin
          nxt_state = BAND;
          nxt_cnt   = above ? 4'd1 : 4'd0;
          nxt_dir   = 1'b1;
        end
      end
      default: begin
        nxt_state = BAND;
        nxt_cnt   = 4'd0;
      end
    endcase
  end

  // A config write and a grant never target the same channel in one cycle.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (reset) begin
        state_reg[i] <= BAND;
        cnt_reg[i]   <= 4'd0;
        dir_reg[i]   <= 1'b0;
        upper_reg[i] <= PRICE_W'(DEF_UPPER);
        lower_reg[i] <= PRICE_W'(DEF_LOWER);
      end else if (cfg_hit && cfg_ch == CHW'(i)) begin
        upper_reg[i] <= cfg_upper;
        lower_reg[i] <= cfg_lower;
        state_reg[i] <= BAND;
        cnt_reg[i]   <= 4'd0;
      end else if (grant[i]) begin
        state_reg[i] <= nxt_state;
        cnt_reg[i]   <= nxt_cnt;
        dir_reg[i]   <= nxt_dir;
      end
    end
  end

  logic smp_evt;
  logic cfg_evt;

  assign smp_evt = acc_valid && (nxt_state != cur_state);
  assign cfg_evt = cfg_hit && (state_reg[cfg_ch] != BAND);

  // Only one event slot per cycle; a market-driven change outranks a config-forced one.
  always_ff @(posedge clk) begin
    if (reset) begin
      evt_valid <= 1'b0;
      evt_ch    <= '0;
      evt_state <= BAND;
      cfg_err   <= 1'b0;
    end else begin
      cfg_err   <= cfg_we && !cfg_ok;
      evt_valid <= smp_evt || cfg_evt;
      if (smp_evt) begin
        evt_ch    <= acc_ch;
        evt_state <= nxt_state;
      end else if (cfg_evt) begin
        evt_ch    <= cfg_ch;
        evt_state <= BAND;
      end
    end
  end

endmodule
